chip8_alu_sequencer: RTL and testbench

//  Executes CHIP-8 8XYN register-register instructions for Chip8_CPU. Reads Vx/Vy

---
 rtl/chip8_alu_sequencer.sv | 136 +++++++++++++
 tb/tb_chip8_alu_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN sequencer: reads Vx/Vy, drives an external ALU, writes the result to Vx
// and then, for ops that define one, the flag to VF. start/done handshake.
module chip8_alu_sequencer #(
  parameter int VF_RESET_LOGIC = 0,
  parameter int SHIFT_USES_VY  = 0
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  reg_raddr1,
  output logic [3:0]  reg_raddr2,
  input  logic [7:0]  reg_rdata1,
  input  logic [7:0]  reg_rdata2,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_sel,
  input  logic [15:0] alu_out
);
  localparam logic [2:0] ALU_f_OR     = 3'd0;
  localparam logic [2:0] ALU_f_AND    = 3'd1;
  localparam logic [2:0] ALU_f_XOR    = 3'd2;
  localparam logic [2:0] ALU_f_ADD    = 3'd3;
  localparam logic [2:0] ALU_f_MINUS  = 3'd4;
  localparam logic [2:0] ALU_f_RSHIFT = 3'd5;
  localparam logic [2:0] ALU_f_LSHIFT = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB_RES, S_WB_FLAG, S_DONE} state_t;
  state_t r_state, w_next;

  logic [11:0] r_op;
  logic [7:0]  r_result;
  logic        r_flag, r_illegal;

  logic [3:0]  w_x, w_y, w_n;
  logic        w_legal, w_has_flag, w_flag;
  logic [7:0]  w_a, w_b, w_s, w_op1, w_op2;
  logic [8:0]  w_sum;
  logic [2:0]  w_sel;
  logic        w_unused;

  assign w_x      = r_op[11:8];
  assign w_y      = r_op[7:4];
  assign w_n      = r_op[3:0];
  assign w_legal  = (opcode[15:12] == 4'h8) && ((opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE));
  assign w_a      = reg_rdata1;
  assign w_b      = reg_rdata2;
  assign w_s      = (SHIFT_USES_VY != 0) ? w_b : w_a;
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_unused = ^alu_out[15:8];

  // Borrow flags are derived locally as a>=b so equal operands report "no borrow".
  always_comb begin
    w_sel      = ALU_f_OR;
    w_op1      = 8'h00;
    w_op2      = 8'h00;
    w_flag     = 1'b0;
    w_has_flag = 1'b1;
    case (w_n)
      4'h0: begin w_op2 = w_b; w_has_flag = 1'b0; end
      4'h1: begin w_op1 = w_a; w_op2 = w_b; w_has_flag = (VF_RESET_LOGIC != 0); end
      4'h2: begin w_sel = ALU_f_AND; w_op1 = w_a; w_op2 = w_b; w_has_flag = (VF_RESET_LOGIC != 0); end
      4'h3: begin w_sel = ALU_f_XOR; w_op1 = w_a; w_op2 = w_b; w_has_flag = (VF_RESET_LOGIC != 0); end
      4'h4: begin w_sel = ALU_f_ADD; w_op1 = w_a; w_op2 = w_b; w_flag = w_sum[8]; end
      4'h5: begin w_sel = ALU_f_MINUS; w_op1 = w_a; w_op2 = w_b; w_flag = (w_a >= w_b); end
      4'h7: begin w_sel = ALU_f_MINUS; w_op1 = w_b; w_op2 = w_a; w_flag = (w_b >= w_a); end
      4'h6: begin w_sel = ALU_f_RSHIFT; w_op1 = w_s; w_op2 = 8'h01; w_flag = w_s[0]; end
      4'hE: begin w_sel = ALU_f_LSHIFT; w_op1 = w_s; w_op2 = 8'h01; w_flag = w_s[7]; end
      default: w_has_flag = 1'b0;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    reg_raddr1 = 4'h0;
    reg_raddr2 = 4'h0;
    reg_we     = 1'b0;
    reg_waddr  = 4'h0;
    reg_wdata  = 8'h00;
    alu_in1    = 16'h0000;
    alu_in2    = 16'h0000;
    alu_sel    = ALU_f_OR;
    case (r_state)
      S_IDLE:    if (start) w_next = w_legal ? S_READ : S_DONE;
      S_READ:    begin reg_raddr1 = w_x; reg_raddr2 = w_y; w_next = S_EXEC; end
      S_EXEC:    begin
        alu_in1 = {8'h00, w_op1};
        alu_in2 = {8'h00, w_op2};
        alu_sel = w_sel;
        w_next  = S_WB_RES;
      end
      S_WB_RES:  begin
        reg_we    = 1'b1;
        reg_waddr = w_x;
        reg_wdata = r_result;
        w_next    = w_has_flag ? S_WB_FLAG : S_DONE;
      end
      // VF goes last so that an op with X==F ends with the flag in VF.
      S_WB_FLAG: begin reg_we = 1'b1; reg_waddr = 4'hF; reg_wdata = {7'b0, r_flag}; w_next = S_DONE; end
      S_DONE:    begin done = 1'b1; illegal = r_illegal; w_next = S_IDLE; end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= 12'h000;
      r_illegal <= 1'b0;
      r_result  <= 8'h00;
      r_flag    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_op      <= opcode[11:0];
        r_illegal <= !w_legal;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_out[7:0];
        r_flag   <= w_flag;
      end
    end
  end
endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer with a small register file and ALU model.
module tb_chip8_alu_sequencer;
  logic        cpu_clk = 1'b0;
  logic        reset_n, start;
  logic [15:0] opcode;
  logic        busy, done, illegal, reg_we;
  logic [3:0]  reg_raddr1, reg_raddr2, reg_waddr;
  logic [7:0]  reg_rdata1, reg_rdata2, reg_wdata;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_sel;

  logic [7:0]  rf [16];
  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [7:0]  tb_wdata;
  int checks = 0;
  int failures = 0;

  chip8_alu_sequencer dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal),
    .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) begin
    reg_rdata1 <= rf[reg_raddr1];
    reg_rdata2 <= rf[reg_raddr2];
    if (reg_we)     rf[reg_waddr] <= reg_wdata;
    else if (tb_we) rf[tb_waddr]  <= tb_wdata;
  end

  // ALU encoding: OR=0 AND=1 XOR=2 ADD=3 MINUS=4 RSHIFT=5 LSHIFT=6
  always_comb begin
    alu_out = 16'h0000;
    case (alu_sel)
      3'd0: alu_out = alu_in1 | alu_in2;
      3'd1: alu_out = alu_in1 & alu_in2;
      3'd2: alu_out = alu_in1 ^ alu_in2;
      3'd3: alu_out = alu_in1 + alu_in2;
      3'd4: alu_out = alu_in1 - alu_in2;
      3'd5: alu_out = alu_in1 >> alu_in2;
      3'd6: alu_out = alu_in1 << alu_in2;
      default: alu_out = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  // Leaves the caller in cycle 1 (first cycle after the start edge).
  task automatic issue(input logic [15:0] op);
    opcode = op; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] op, input int exp_lat, input string tag);
    int lat;
    issue(op);
    lat = 1;
    while (!done && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
    chk({tag, " illegal"}, 16'(illegal), 16'h0);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 16'h0000;
    tb_we = 1'b0; tb_waddr = 4'h0; tb_wdata = 8'h00;
    #2;
    chk("rst busy",   16'(busy), 16'h0);
    chk("rst done",   16'({done, illegal, reg_we}), 16'h0);
    chk("rst addrs",  {reg_raddr1, reg_raddr2, reg_waddr, 4'h0}, 16'h0);
    chk("rst wdata",  16'(reg_wdata), 16'h0);
    chk("rst alu_in", alu_in1 | alu_in2, 16'h0);
    chk("rst alu_sel", 16'(alu_sel), 16'h0);
    repeat (2) @(posedge cpu_clk);
    #1 reset_n = 1'b1;

    // T1: ADD with carry, cycle-by-cycle
    poke(4'h1, 8'hF0); poke(4'h2, 8'h20); poke(4'hF, 8'h00);
    issue(16'h8124);
    chk("t1 c1 busy",  16'(busy), 16'h1);
    chk("t1 c1 raddr", {8'h00, reg_raddr1, reg_raddr2}, 16'h0012);
    chk("t1 c1 we",    16'(reg_we), 16'h0);
    tick();
    chk("t1 c2 sel",   16'(alu_sel), 16'h3);
    chk("t1 c2 in1",   alu_in1, 16'h00F0);
    chk("t1 c2 in2",   alu_in2, 16'h0020);
    tick();
    chk("t1 c3 write", {3'b0, reg_we, reg_waddr, reg_wdata}, 16'h1110);
    tick();
    chk("t1 c4 write", {3'b0, reg_we, reg_waddr, reg_wdata}, 16'h1F01);
    chk("t1 c4 done",  16'(done), 16'h0);
    tick();
    chk("t1 c5 done",  16'({done, illegal, reg_we}), 16'h4);
    tick();
    chk("t1 c6 idle",  16'({busy, done}), 16'h0);
    chk("t1 V1", 16'(rf[1]), 16'h0010);
    chk("t1 VF", 16'(rf[15]), 16'h0001);

    // T2: SUB, equal and borrow
    poke(4'h3, 8'h55); poke(4'h4, 8'h55);
    run(16'h8345, 5, "t2a");
    chk("t2a V3", 16'(rf[3]), 16'h0000);
    chk("t2a VF", 16'(rf[15]), 16'h0001);
    poke(4'h3, 8'h10); poke(4'h4, 8'h20);
    run(16'h8345, 5, "t2b");
    chk("t2b V3", 16'(rf[3]), 16'h00F0);
    chk("t2b VF", 16'(rf[15]), 16'h0000);

    // T3: X==F, flag overwrites the result
    poke(4'hF, 8'hF0); poke(4'h1, 8'h20);
    run(16'h8F14, 5, "t3");
    chk("t3 VF", 16'(rf[15]), 16'h0001);

    // T4: shifts act on Vx
    poke(4'h5, 8'h81); poke(4'h6, 8'h00);
    run(16'h856E, 5, "t4 shl");
    chk("t4 shl V5", 16'(rf[5]), 16'h0002);
    chk("t4 shl VF", 16'(rf[15]), 16'h0001);
    poke(4'h5, 8'h81); poke(4'hF, 8'h00);
    run(16'h8566, 5, "t4 shr");
    chk("t4 shr V5", 16'(rf[5]), 16'h0040);
    chk("t4 shr VF", 16'(rf[15]), 16'h0001);

    // Logic ops and move: no VF write, 4-cycle latency
    poke(4'hF, 8'h77); poke(4'h1, 8'h3C); poke(4'h2, 8'hA5);
    run(16'h8121, 4, "or");
    chk("or V1", 16'(rf[1]), 16'h00BD);
    poke(4'h1, 8'h3C);
    run(16'h8122, 4, "and");
    chk("and V1", 16'(rf[1]), 16'h0024);
    poke(4'h1, 8'h3C);
    run(16'h8123, 4, "xor");
    chk("xor V1", 16'(rf[1]), 16'h0099);
    run(16'h8120, 4, "mov");
    chk("mov V1", 16'(rf[1]), 16'h00A5);
    chk("logic VF kept", 16'(rf[15]), 16'h0077);

    // SUBN both ways, and X==Y add
    poke(4'h1, 8'h10); poke(4'h2, 8'h30);
    run(16'h8127, 5, "subn a");
    chk("subn a V1", 16'(rf[1]), 16'h0020);
    chk("subn a VF", 16'(rf[15]), 16'h0001);
    poke(4'h1, 8'h30); poke(4'h2, 8'h10);
    run(16'h8127, 5, "subn b");
    chk("subn b V1", 16'(rf[1]), 16'h00E0);
    chk("subn b VF", 16'(rf[15]), 16'h0000);
    poke(4'h2, 8'h90);
    run(16'h8224, 5, "xeqy");
    chk("xeqy V2", 16'(rf[2]), 16'h0020);
    chk("xeqy VF", 16'(rf[15]), 16'h0001);

    // T5: illegal opcodes, and a start while busy is dropped
    poke(4'h1, 8'h0F); poke(4'h2, 8'hF0);
    issue(16'h8128);
    chk("t5 ill N done", 16'({busy, done, illegal, reg_we}), 16'hE);
    tick();
    chk("t5 ill N idle", 16'({busy, done, illegal}), 16'h0);
    issue(16'h9124);
    chk("t5 ill hi done", 16'({done, illegal, reg_we}), 16'h6);
    tick();
    chk("t5 ill V1", 16'(rf[1]), 16'h000F);
    issue(16'h8121);
    tick();
    start = 1'b1; opcode = 16'h8128;
    tick();
    start = 1'b0;
    tick();
    chk("t5 busy-start done", 16'({done, illegal}), 16'h2);
    tick();
    chk("t5 not queued", 16'({busy, done}), 16'h0);
    tick();
    chk("t5 still idle", 16'(busy), 16'h0);
    chk("t5 V1", 16'(rf[1]), 16'h00FF);

    // T6: reset during the VF write
    poke(4'h1, 8'hF0); poke(4'h2, 8'h20); poke(4'hF, 8'h33);
    issue(16'h8124);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("t6 rst busy", 16'({busy, reg_we, done}), 16'h0);
    tick();
    reset_n = 1'b1;
    chk("t6 V1 kept", 16'(rf[1]), 16'h0010);
    chk("t6 VF untouched", 16'(rf[15]), 16'h0033);
    poke(4'h1, 8'h01); poke(4'h2, 8'h02);
    run(16'h8124, 5, "t6 after");
    chk("t6 after V1", 16'(rf[1]), 16'h0003);
    chk("t6 after VF", 16'(rf[15]), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
